// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes a MIPS instruction into ALU operands/opcode,
// write-back and branch info, with stall (hold) and flush (bubble) support.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        op2,
    output logic        op1,
    output logic        op0,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_is_beq,
    output logic [31:0] ex_target,
    output logic        ex_illegal
);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_op;
    logic        r_valid;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_is_beq;
    logic [31:0] r_target;
    logic        r_illegal;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;

    logic        w_legal;
    logic [2:0]  w_dec_op;
    logic [31:0] w_dec_b;
    logic [4:0]  w_dec_rd;
    logic        w_dec_beq;
    logic [31:0] w_dec_target;

    logic [31:0] w_nxt_a;
    logic [31:0] w_nxt_b;
    logic [2:0]  w_nxt_op;
    logic        w_nxt_valid;
    logic [4:0]  w_nxt_rd;
    logic        w_nxt_reg_write;
    logic        w_nxt_beq;
    logic [31:0] w_nxt_target;
    logic        w_nxt_illegal;

    assign w_opcode   = instr[31:26];
    assign w_funct    = instr[5:0];
    assign w_imm      = instr[15:0];
    assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
    assign w_imm_zext = {16'h0000, w_imm};

    // Instruction decode into candidate stage contents
    always_comb begin
        w_legal      = 1'b0;
        w_dec_op     = ALU_AND;
        w_dec_b      = 32'h0000_0000;
        w_dec_rd     = 5'd0;
        w_dec_beq    = 1'b0;
        w_dec_target = 32'h0000_0000;
        case (w_opcode)
            OPC_RTYPE: begin
                w_dec_b  = rt_data;
                w_dec_rd = instr[15:11];
                case (w_funct)
                    FN_AND:  begin w_legal = 1'b1; w_dec_op = ALU_AND; end
                    FN_OR:   begin w_legal = 1'b1; w_dec_op = ALU_OR;  end
                    FN_ADD:  begin w_legal = 1'b1; w_dec_op = ALU_ADD; end
                    FN_SUB:  begin w_legal = 1'b1; w_dec_op = ALU_SUB; end
                    FN_XOR:  begin w_legal = 1'b1; w_dec_op = ALU_XOR; end
                    default: begin w_legal = 1'b0; w_dec_op = ALU_AND; end
                endcase
            end
            OPC_ADDI: begin
                w_legal  = 1'b1;
                w_dec_op = ALU_ADD;
                w_dec_b  = w_imm_sext;
                w_dec_rd = instr[20:16];
            end
            OPC_ANDI: begin
                w_legal  = 1'b1;
                w_dec_op = ALU_AND;
                w_dec_b  = w_imm_zext;
                w_dec_rd = instr[20:16];
            end
            OPC_ORI: begin
                w_legal  = 1'b1;
                w_dec_op = ALU_OR;
                w_dec_b  = w_imm_zext;
                w_dec_rd = instr[20:16];
            end
            OPC_XORI: begin
                w_legal  = 1'b1;
                w_dec_op = ALU_XOR;
                w_dec_b  = w_imm_zext;
                w_dec_rd = instr[20:16];
            end
            OPC_BEQ: begin
                w_legal      = 1'b1;
                w_dec_op     = ALU_SUB;
                w_dec_b      = rt_data;
                w_dec_beq    = 1'b1;
                w_dec_target = pc + 32'd4 + {w_imm_sext[29:0], 2'b00};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Next-state selection: flush > stall > load (reset handled in the register)
    always_comb begin
        w_nxt_a         = 32'h0000_0000;
        w_nxt_b         = 32'h0000_0000;
        w_nxt_op        = 3'b000;
        w_nxt_valid     = 1'b0;
        w_nxt_rd        = 5'd0;
        w_nxt_reg_write = 1'b0;
        w_nxt_beq       = 1'b0;
        w_nxt_target    = 32'h0000_0000;
        w_nxt_illegal   = 1'b0;
        if (flush) begin
            w_nxt_valid = 1'b0;
        end else if (stall) begin
            w_nxt_a         = r_alu_a;
            w_nxt_b         = r_alu_b;
            w_nxt_op        = r_op;
            w_nxt_valid     = r_valid;
            w_nxt_rd        = r_rd;
            w_nxt_reg_write = r_reg_write;
            w_nxt_beq       = r_is_beq;
            w_nxt_target    = r_target;
            w_nxt_illegal   = r_illegal;
        end else if (in_valid && w_legal) begin
            w_nxt_a         = rs_data;
            w_nxt_b         = w_dec_b;
            w_nxt_op        = w_dec_op;
            w_nxt_valid     = 1'b1;
            w_nxt_rd        = w_dec_rd;
            w_nxt_reg_write = !w_dec_beq && (w_dec_rd != 5'd0);
            w_nxt_beq       = w_dec_beq;
            w_nxt_target    = w_dec_target;
        end else begin
            // undecodable instruction leaves a bubble that only flags itself
            w_nxt_illegal = in_valid;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_a     <= 32'h0000_0000;
            r_alu_b     <= 32'h0000_0000;
            r_op        <= 3'b000;
            r_valid     <= 1'b0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_is_beq    <= 1'b0;
            r_target    <= 32'h0000_0000;
            r_illegal   <= 1'b0;
        end else begin
            r_alu_a     <= w_nxt_a;
            r_alu_b     <= w_nxt_b;
            r_op        <= w_nxt_op;
            r_valid     <= w_nxt_valid;
            r_rd        <= w_nxt_rd;
            r_reg_write <= w_nxt_reg_write;
            r_is_beq    <= w_nxt_beq;
            r_target    <= w_nxt_target;
            r_illegal   <= w_nxt_illegal;
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign op2          = r_op[2];
    assign op1          = r_op[1];
    assign op0          = r_op[0];
    assign ex_valid     = r_valid;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write;
    assign ex_is_beq    = r_is_beq;
    assign ex_target    = r_target;
    assign ex_illegal   = r_illegal;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/issue pipeline register that sits directly upstream of `alu_32bit`. It decodes a fetched MIPS instruction and registers the ALU operands `alu_a`/`alu_b` and the 3-bit ALU opcode (`op2 op1 op0`). It also registers the destination and branch information needed by the downstream write-back and branch logic. It supports stall (hold) and flush (bubble insertion) from the hazard unit, with one cycle of latency.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register indices).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `in_valid`  in  1  `instr`/`pc`/`rs_data`/`rt_data` hold a real instruction this cycle.
- `instr`  in  32  fetched instruction word.
- `pc`  in  32  address of `instr`.
- `rs_data`  in  32  register-file read of `instr[25:21]`.
- `rt_data`  in  32  register-file read of `instr[20:16]`.
- `stall`  in  1  hold all outputs unchanged.
- `flush`  in  1  replace stage contents with a bubble.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `op2`, `op1`, `op0`  out  1 each  ALU opcode: AND=000, OR=001, ADD=010, XOR=011, SUB=110.
- `ex_valid`  out  1  stage holds a legal instruction.
- `ex_rd`  out  5  write-back destination register.
- `ex_reg_write`  out  1  write-back enable.
- `ex_is_beq`  out  1  instruction is BEQ; downstream takes branch when ALU `ifBeq`=1.
- `ex_target`  out  32  BEQ target = `pc` + 4 + (sign-extended imm16 << 2), mod 2^32.
- `ex_illegal`  out  1  last loaded instruction was undecodable.

## Operation
- Update priority per rising edge: `reset` > `flush` > `stall` > load.
- Reset and flush both produce a bubble: every output 0, including opcode 000, `ex_rd`=0, `ex_target`=0 and `ex_illegal`=0.
- Stall: all outputs keep their previous values. `in_*` are ignored.
- Load with `in_valid`=0: bubble.
- Load with `in_valid`=1: decode `opcode=instr[31:26]`, `funct=instr[5:0]`, `imm=instr[15:0]`. In every case `alu_a`=`rs_data`.
  - R-type (opcode 000000): `alu_b`=`rt_data`, `ex_rd`=`instr[15:11]`.
    - funct 100100 AND→000.
    - 100101 OR→001.
    - 100000 ADD→010.
    - 100010 SUB→110.
    - 100110 XOR→011.
  - ADDI 001000: op 010, `alu_b`=sign-extended imm, `ex_rd`=`instr[20:16]`.
  - ANDI 001100: op 000, `alu_b`=zero-extended imm, `ex_rd`=rt.
  - ORI 001101: op 001, `alu_b`=zero-extended imm, `ex_rd`=rt.
  - XORI 001110: op 011, `alu_b`=zero-extended imm, `ex_rd`=rt.
  - BEQ 000100: op 110, `alu_b`=`rt_data`, `ex_is_beq`=1, `ex_reg_write`=0, `ex_rd`=0, `ex_target` computed.
  - Any other opcode, or an unlisted R-type funct: bubble, except `ex_illegal`=1.
- `ex_reg_write`=1 only for decoded R-type/immediate instructions whose `ex_rd`≠0. A write to $zero is suppressed, but `ex_valid` stays 1.
- `ex_target` is 0 for non-BEQ instructions. The target adder wraps at 2^32 with no overflow flag.
- Sign extension replicates `imm[15]` into bits 31:16. Zero extension fills bits 31:16 with 0.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- All outputs are registered; there are no combinational paths from input to output.
- `ex_illegal` is a registered flag. It holds during stall and clears on the next load, flush or reset.
- `stall` and `flush` in the same cycle: flush wins, giving a bubble.
- Reset asserted mid-stream: the next edge gives a bubble regardless of `stall`/`flush`/`in_valid`. The first load happens at the first edge with `reset`=0.
- Back-to-back loads with `stall`=0 accept one instruction per cycle.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with random inputs → all outputs 0, `ex_valid`=0.
- R-type SUB: `instr`=0x00221822 (sub $3,$1,$2), `rs_data`=5, `rt_data`=3 → `op`=110, `alu_a`=5, `alu_b`=3, `ex_rd`=3, `ex_reg_write`=1, `ex_valid`=1.
- Immediate extension:
  - ADDI `instr`=0x2021FFFF, `rs_data`=1 → `alu_b`=0xFFFFFFFF, op 010, `ex_rd`=1.
  - ORI `instr`=0x3421FFFF → `alu_b`=0x0000FFFF, op 001.
- BEQ: `instr`=0x1022FFFF, `pc`=0x00000010 → op 110, `ex_is_beq`=1, `ex_reg_write`=0, `ex_target`=0x00000010.
- Stall/flush:
  - Load AND.
  - Then `stall`=1 for 3 cycles with a different `instr` → outputs unchanged.
  - Then `stall`=1 and `flush`=1 → bubble.
  - Then ADD to $0 (`instr`=0x00220020) → `ex_valid`=1, `ex_reg_write`=0.
- Illegal: `instr`=0xFC000000 → `ex_illegal`=1, `ex_valid`=0. The next legal load clears `ex_illegal`.
